uart_tx_arbiter: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 116 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART TX arbiter slice.
// Optional build macro used by the slice: UART_TX_ARB_LOCK_EN (packet lock).
package uart_pkg;

    // Width of one transmitted character.
    localparam int UART_DW = 8;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int uart_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus transmitter handshake of the arbiter.
// With UART_TX_ARB_LOCK_EN defined a per-requester lock vector is added.
// slave  : the arbiter.  master : the requesters and transmitter around it.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 4
);
    import uart_pkg::*;

    logic [N_REQ-1:0]         req;
    logic [UART_DW*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]         ack;
    logic [N_REQ-1:0]         gnt;
    logic                     tx_start;
    logic [UART_DW-1:0]       tx_data;
    logic                     tx_busy;
    logic                     arb_busy;
`ifdef UART_TX_ARB_LOCK_EN
    logic [N_REQ-1:0]         lock;

    modport master (output req, req_data, lock, tx_busy,
                    input  ack, gnt, tx_start, tx_data, arb_busy);
    modport slave  (input  req, req_data, lock, tx_busy,
                    output ack, gnt, tx_start, tx_data, arb_busy);
`else
    modport master (output req, req_data, tx_busy,
                    input  ack, gnt, tx_start, tx_data, arb_busy);
    modport slave  (input  req, req_data, tx_busy,
                    output ack, gnt, tx_start, tx_data, arb_busy);
`endif

endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin search. Returns the first set
// request at or after i_ptr, wrapping from N_REQ-1 back to 0.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = uart_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        // NOTE: every variable is given a default before the loop so no path leaves it unassigned and no latch is inferred.
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one byte-wide UART transmitter.
// The winner's byte is captured at grant and offered with a level
// tx_start / tx_busy handshake, so a slow clock-enabled transmitter is fine.
// Optional macro UART_TX_ARB_LOCK_EN: a locked owner that still requests is
// re-granted straight from WAIT_DONE, keeping multi-byte packets contiguous.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    uart_tx_arbiter_if.slave  bus
);

    localparam int IDX_W = uart_idx_w(N_REQ);

    arb_state_e         r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_tx_start;
    logic [UART_DW-1:0] r_tx_data;

    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_ptr_next;
    logic               w_relock;
    logic [UART_DW-1:0] w_bytes [N_REQ];

    uart_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (bus.req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    // Split the flat data bus into one byte per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            w_bytes[i] = bus.req_data[i*UART_DW +: UART_DW];
        end
    end

    assign w_ptr_next = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_TX_ARB_LOCK_EN
    assign w_relock = bus.lock[r_owner] & bus.req[r_owner];
`else
    assign w_relock = 1'b0;
`endif

    // Arbiter FSM: grant and capture in IDLE, hold start in ISSUE, wait for the frame in WAIT_DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_owner    <= '0;
            r_ptr      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here updates from pre-edge values, independent of statement order.
            r_ack <= '0;
            case (r_state)
                IDLE: begin
                    if (w_valid && !bus.tx_busy) begin
                        r_gnt      <= N_REQ'(1) << w_idx;
                        r_owner    <= w_idx;
                        r_tx_data  <= w_bytes[w_idx];
                        r_tx_start <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.tx_busy) begin
                        r_ack      <= r_gnt;
                        r_tx_start <= 1'b0;
                        r_state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        if (w_relock) begin
                            // Same owner keeps the line; take its next byte, pointer untouched.
                            r_tx_data  <= w_bytes[r_owner];
                            r_tx_start <= 1'b1;
                            r_state    <= ISSUE;
                        end else begin
                            r_ptr   <= w_ptr_next;
                            r_gnt   <= '0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_gnt      <= '0;
                    r_tx_start <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack      = r_ack;
    assign bus.gnt      = r_gnt;
    assign bus.tx_start = r_tx_start;
    assign bus.tx_data  = r_tx_data;
    assign bus.arb_busy = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter.
// Requesters are driven in batches; a queue-based round-robin model predicts
// the byte/owner order, and independent monitors (transmitter model, ack
// watcher) pop and compare. Honours UART_TX_ARB_LOCK_EN when defined.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 40000;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Requester-side drive, one element per requester.
    logic       req_a  [N];
    logic [7:0] data_a [N];
    logic       lock_a [N];

    always_comb begin
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < N; i++) begin
            bus.req[i]            = req_a[i];
            bus.req_data[8*i +: 8] = data_a[i];
        end
    end
`ifdef UART_TX_ARB_LOCK_EN
    always_comb begin
        bus.lock = '0;
        for (int i = 0; i < N; i++) bus.lock[i] = lock_a[i];
    end
`endif

    // Transmitter model controls.
    logic model_busy = 1'b0;
    logic ext_busy   = 1'b0;
    int   dmin = 0, dmax = 3, hmin = 2, hmax = 8;
    assign bus.tx_busy = model_busy | ext_busy;

    // Batch description and scoreboard.
    int         b_cnt  [N];
    logic [7:0] b_dat  [N][4];
    bit         b_lock [N];
    int         model_ptr = 0;
    int         exp_idx_q [$];
    logic [7:0] exp_dat_q [$];
    logic [N-1:0] exp_ack_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Reference: serve the batch round-robin over requesters that still have bytes left.
    task automatic model_batch();
        int left [N];
        int nxt  [N];
        int p, cur, total;
        bit relock;
        p = model_ptr; cur = 0; total = 0; relock = 1'b0;
        for (int i = 0; i < N; i++) begin
            left[i] = b_cnt[i];
            nxt[i]  = 0;
            total  += b_cnt[i];
        end
        for (int n = 0; n < total; n++) begin
            if (!relock) begin
                for (int s = 0; s < N; s++) begin
                    if (left[(p + s) % N] > 0) begin
                        cur = (p + s) % N;
                        break;
                    end
                end
            end
            exp_idx_q.push_back(cur);
            exp_dat_q.push_back(b_dat[cur][nxt[cur]]);
            exp_ack_q.push_back(N'(1) << cur);
            nxt[cur]++;
            left[cur]--;
            relock = LOCK && b_lock[cur] && (left[cur] > 0);
            if (!relock) p = (cur + 1) % N;
        end
        model_ptr = p;
    endtask

    // One requester: present each byte, scramble data once captured, move on after ack.
    task automatic requester(input int i);
        bit ok;
        for (int b = 0; b < b_cnt[i]; b++) begin
            req_a[i]  = 1'b1;
            data_a[i] = b_dat[i][b];
            lock_a[i] = b_lock[i];
            ok = 1'b0;
            for (int c = 0; c < TMO; c++) begin
                @(negedge clk);
                if (bus.gnt[i] && bus.tx_start) begin ok = 1'b1; break; end
            end
            if (!ok) begin fail_now("grant_wait"); break; end
            data_a[i] = ~b_dat[i][b];
            ok = 1'b0;
            for (int c = 0; c < TMO; c++) begin
                @(negedge clk);
                if (bus.ack[i]) begin ok = 1'b1; break; end
            end
            if (!ok) begin fail_now("ack_wait"); break; end
        end
        req_a[i]  = 1'b0;
        lock_a[i] = 1'b0;
    endtask

    task automatic run_batch();
        model_batch();
        for (int i = 0; i < N; i++) begin
            automatic int ii = i;
            fork
                requester(ii);
            join_none
        end
        wait fork;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            if (!bus.arb_busy && !bus.tx_busy) begin ok = 1'b1; break; end
        end
        if (!ok) fail_now("idle_wait");
    endtask

    task automatic set_batch(input int c0, c1, c2, c3);
        b_cnt[0] = c0; b_cnt[1] = c1; b_cnt[2] = c2; b_cnt[3] = c3;
        for (int i = 0; i < N; i++) begin
            b_lock[i] = 1'b0;
            for (int b = 0; b < 4; b++) b_dat[i][b] = 8'($urandom);
        end
    endtask

    // Transmitter model and data monitor: accept on tx_start, compare the byte and owner.
    initial begin : tx_model
        int d, h, gap, last_fall, idx;
        last_fall = -100;
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1 && !model_busy && !ext_busy) begin
                gap = cyc - last_fall;
                if (!LOCK) check("start_gap_ge2", 32'(gap >= 2), 32'd1);
                d = $urandom_range(dmax, dmin);
                repeat (d) @(negedge clk);
                model_busy = 1'b1;
                if (exp_dat_q.size() == 0) begin
                    check("unexpected_byte", 32'(bus.tx_data), 32'hFFFF);
                end else begin
                    idx = exp_idx_q.pop_front();
                    check("tx_data", 32'(bus.tx_data), 32'(exp_dat_q.pop_front()));
                    check("gnt_owner", 32'(bus.gnt), 32'(N'(1) << idx));
                end
                h = $urandom_range(hmax, hmin);
                repeat (h) @(negedge clk);
                model_busy = 1'b0;
                last_fall  = cyc;
            end
        end
    end

    // Ack monitor plus per-cycle grant sanity.
    initial begin : ack_mon
        forever begin
            @(negedge clk);
            check("gnt_onehot0", 32'($onehot0(bus.gnt) && !$isunknown(bus.gnt)), 32'd1);
            if (bus.ack !== '0) begin
                if (exp_ack_q.size() == 0) check("unexpected_ack", 32'(bus.ack), 32'd0);
                else check("ack", 32'(bus.ack), 32'(exp_ack_q.pop_front()));
            end
        end
    end

    initial begin : main
        bit saw;
        for (int i = 0; i < N; i++) begin req_a[i] = 1'b0; data_a[i] = '0; lock_a[i] = 1'b0; end
        rst_n = 1'b0;

        // Reset with all requesting, then the slow-transmitter fairness run.
        set_batch(2, 1, 1, 1);
        b_dat[0][0] = 8'h11; b_dat[0][1] = 8'h11;
        b_dat[1][0] = 8'h22; b_dat[2][0] = 8'h33; b_dat[3][0] = 8'h44;
        dmin = 28; dmax = 28; hmin = 4480; hmax = 4480;
        fork
            run_batch();
            begin
                repeat (3) @(negedge clk);
                check("rst_gnt", 32'(bus.gnt), 32'd0);
                check("rst_tx_start", 32'(bus.tx_start), 32'd0);
                check("rst_ack", 32'(bus.ack), 32'd0);
                check("rst_arb_busy", 32'(bus.arb_busy), 32'd0);
                check("rst_tx_data", 32'(bus.tx_data), 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                check("first_gnt", 32'(bus.gnt), 32'b0001);
                check("first_tx_data", 32'(bus.tx_data), 32'h11);
                check("first_tx_start", 32'(bus.tx_start), 32'd1);
            end
        join
        wait_idle();
        dmin = 0; dmax = 4; hmin = 2; hmax = 10;

        // Transmitter busy externally: nothing may start until it falls.
        set_batch(0, 1, 0, 0);
        b_dat[1][0] = 8'h5A;
        ext_busy = 1'b1;
        fork
            run_batch();
            begin
                saw = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    if (bus.tx_start || bus.gnt != '0) saw = 1'b1;
                end
                check("busy_blocks_start", 32'(saw), 32'd0);
                ext_busy = 1'b0;
                @(negedge clk);
                check("start_after_busy", 32'(bus.tx_start), 32'd1);
                check("gnt_after_busy", 32'(bus.gnt), 32'b0010);
            end
        join
        wait_idle();

        // Pointer wrap: serve req2 (pointer to 3), then req0 and req3 compete.
        set_batch(0, 0, 1, 0);
        run_batch();
        wait_idle();
        set_batch(1, 0, 0, 1);
        run_batch();
        wait_idle();

        // Reset during WAIT_DONE.
        set_batch(0, 1, 0, 0);
        run_batch();
        wait_idle();
        hmin = 40; hmax = 40;
        set_batch(0, 0, 1, 0);
        run_batch();
        repeat (2) @(negedge clk);
        check("pre_rst_arb_busy", 32'(bus.arb_busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx_start", 32'(bus.tx_start), 32'd0);
        check("async_rst_gnt", 32'(bus.gnt), 32'd0);
        check("async_rst_arb_busy", 32'(bus.arb_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = 0;
        wait_idle();
        hmin = 2; hmax = 10;
        set_batch(1, 0, 1, 0);
        run_batch();
        wait_idle();

`ifdef UART_TX_ARB_LOCK_EN
        // Locked packet from req0 stays contiguous ahead of req1.
        set_batch(3, 1, 0, 0);
        b_lock[0] = 1'b1;
        run_batch();
        wait_idle();
`endif

        // Randomised batches.
        for (int t = 0; t < 30; t++) begin
            set_batch($urandom_range(3, 0), $urandom_range(3, 0),
                      $urandom_range(3, 0), $urandom_range(3, 0));
            for (int i = 0; i < N; i++) b_lock[i] = 1'($urandom_range(1, 0));
            hmin = 1 + $urandom_range(2, 1);
            hmax = hmin + $urandom_range(12, 0);
            run_batch();
            wait_idle();
        end

        repeat (4) @(negedge clk);
        check("data_queue_drained", 32'(exp_dat_q.size()), 32'd0);
        check("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
